// File: rtl/arbiter_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arbiter_mux: N-to-1 registered mux with valid/ready and built-in arbiter  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module arbiter_mux #(
  parameter int CHANNELS = 4,
  parameter int BUS_SIZE = 32,
  parameter int ARB_MODE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          in_valid,
  input  logic [CHANNELS*BUS_SIZE-1:0] data_in,
  output logic [CHANNELS-1:0]          in_ready,
  output logic [BUS_SIZE-1:0]          data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(CHANNELS)-1:0]  grant
);

  localparam int SEL_W = $clog2(CHANNELS);

  logic                out_valid_q, out_valid_d;
  logic [BUS_SIZE-1:0] data_q, data_d;
  logic [SEL_W-1:0]    grant_q, grant_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic [SEL_W-1:0]    sel;
  logic                found;
  logic                load;
  logic                xfer;

  // Explicit wrap so non-power-of-two channel counts never index past the top.
  function automatic int wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    return sum;
  endfunction

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ARB_MODE == 0) begin
        if (!found && in_valid[k]) begin
          sel   = SEL_W'(k);
          found = 1'b1;
        end
      end else begin
        if (!found && in_valid[wrap_idx(int'(ptr_q), k)]) begin
          sel   = SEL_W'(wrap_idx(int'(ptr_q), k));
          found = 1'b1;
        end
      end
    end
  end

  assign load = ~out_valid_q | out_ready;
  assign xfer = load & (|in_valid) & ~reset;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[sel] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      data_d      = data_in[int'(sel)*BUS_SIZE +: BUS_SIZE];
      grant_d     = sel;
      ptr_d       = (int'(sel) == CHANNELS-1) ? '0 : sel + 1'b1;
    end else if (out_ready) begin
      // Drain with nothing to refill: only the valid flag drops.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign grant     = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_mux.sv
`default_nettype none
// Testbench for arbiter_mux: directed vector table on a 4-channel round-robin
// instance, plus hand-written sequences for fixed priority and 3-channel wrap.
module tb_arbiter_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel round-robin instance
  logic         rr_rst, rr_ordy, rr_ov;
  logic [3:0]   rr_iv, rr_ir;
  logic [127:0] rr_din;
  logic [31:0]  rr_dout;
  logic [1:0]   rr_g;

  // 4-channel fixed-priority instance
  logic         fp_rst, fp_ordy, fp_ov;
  logic [3:0]   fp_iv, fp_ir;
  logic [127:0] fp_din;
  logic [31:0]  fp_dout;
  logic [1:0]   fp_g;

  // 3-channel round-robin instance, 8-bit words
  logic         r3_rst, r3_ordy, r3_ov;
  logic [2:0]   r3_iv, r3_ir;
  logic [23:0]  r3_din;
  logic [7:0]   r3_dout;
  logic [1:0]   r3_g;

  arbiter_mux #(.CHANNELS(4), .BUS_SIZE(32), .ARB_MODE(1)) u_rr (
    .clk(clk), .reset(rr_rst), .in_valid(rr_iv), .data_in(rr_din), .in_ready(rr_ir),
    .data_out(rr_dout), .out_valid(rr_ov), .out_ready(rr_ordy), .grant(rr_g));

  arbiter_mux #(.CHANNELS(4), .BUS_SIZE(32), .ARB_MODE(0)) u_fp (
    .clk(clk), .reset(fp_rst), .in_valid(fp_iv), .data_in(fp_din), .in_ready(fp_ir),
    .data_out(fp_dout), .out_valid(fp_ov), .out_ready(fp_ordy), .grant(fp_g));

  arbiter_mux #(.CHANNELS(3), .BUS_SIZE(8), .ARB_MODE(1)) u_r3 (
    .clk(clk), .reset(r3_rst), .in_valid(r3_iv), .data_in(r3_din), .in_ready(r3_ir),
    .data_out(r3_dout), .out_valid(r3_ov), .out_ready(r3_ordy), .grant(r3_g));

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0001;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h4444_0003;

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [31:0] dout;
    logic [1:0]  g;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rr_din = {D3, D2, D1, D0};
    fp_din = {D3, D2, D1, D0};
    r3_din = {8'h12, 8'h11, 8'h10};
    rr_rst = 1'b1; rr_iv = '0; rr_ordy = 1'b1;
    fp_rst = 1'b1; fp_iv = '0; fp_ordy = 1'b1;
    r3_rst = 1'b1; r3_iv = '0; r3_ordy = 1'b1;

    //           rst  iv       ordy  ir       ov    dout   g
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0}); // reset state, in_ready gated
    tbl.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 32'h0, 2'd0}); // single channel 2
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, D2,    2'd2}); // DEADBEEF lands
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, D2,    2'd2}); // drained, data held
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0, D2,    2'd2}); // ptr=3 after ch2
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, D3,    2'd3}); // wraps to 0
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, D0,    2'd0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, D1,    2'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, D2,    2'd2});
    tbl.push_back('{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, D3,    2'd3}); // load A from ch0
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, D0,    2'd0}); // stall x5
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, D0,    2'd0});
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, D0,    2'd0});
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, D0,    2'd0});
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, D0,    2'd0});
    tbl.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, D0,    2'd0}); // release: drain+load
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, D1,    2'd1}); // reset with ptr=2, full
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 32'h0, 2'd0}); // cleared, grant ch0 first
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, D0,    2'd0}); // stall gates in_ready
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, D0,    2'd0});

    tick();
    foreach (tbl[i]) begin
      rr_rst  = tbl[i].rst;
      rr_iv   = tbl[i].iv;
      rr_ordy = tbl[i].ordy;
      #1;
      chk("rr_in_ready",  i, 64'(rr_ir),   64'(tbl[i].ir));
      chk("rr_out_valid", i, 64'(rr_ov),   64'(tbl[i].ov));
      chk("rr_data_out",  i, 64'(rr_dout), 64'(tbl[i].dout));
      chk("rr_grant",     i, 64'(rr_g),    64'(tbl[i].g));
      tick();
    end

    // Fixed priority: channel 1 always beats channel 3.
    fp_rst = 1'b0;
    fp_iv  = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fp_in_ready", k, 64'(fp_ir), 64'(4'b0010));
      if (k > 0) begin
        chk("fp_grant", k, 64'(fp_g),    64'(2'd1));
        chk("fp_data",  k, 64'(fp_dout), 64'(D1));
      end
      tick();
    end
    fp_iv = 4'b1100;
    #1;
    chk("fp_in_ready_hi", 0, 64'(fp_ir), 64'(4'b0100));
    tick();
    fp_iv = 4'b0000;
    #1;
    chk("fp_grant_hi", 0, 64'(fp_g),    64'(2'd2));
    chk("fp_data_hi",  0, 64'(fp_dout), 64'(D2));

    // Three channels: rotation must wrap 2 -> 0 without visiting index 3.
    r3_rst = 1'b0;
    r3_iv  = 3'b111;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("r3_in_ready", k, 64'(r3_ir), 64'(3'b001 << (k % 3)));
      if (k > 0) begin
        chk("r3_grant", k, 64'(r3_g),    64'((k - 1) % 3));
        chk("r3_data",  k, 64'(r3_dout), 64'(8'h10 + 8'((k - 1) % 3)));
        chk("r3_valid", k, 64'(r3_ov),   64'(1'b1));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arbiter_mux.md
# arbiter_mux

Registered N-to-1 bus multiplexer with per-channel valid/ready handshakes and built-in arbitration, replacing externally driven selectors where several producers share one consumer, e.g. multiple requesters into a memory or peripheral port. Each cycle it picks one requesting channel by fixed priority or round-robin. It accepts that channel's word into a single-entry output register and presents it downstream until the sink takes it. Throughput is one word per cycle when the sink is always ready.

## Interface
Parameters:
- CHANNELS, 4, number of input channels; legal range 2..32, any value (power of two not required).
- BUS_SIZE, 32, width of each channel word in bits.
- ARB_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  CHANNELS  bit i set = channel i offers a word.
- data_in  input  CHANNELS*BUS_SIZE  packed words; channel i at bits [i*BUS_SIZE +: BUS_SIZE].
- in_ready  output  CHANNELS  one-hot or zero; bit i set = channel i's word is accepted this cycle.
- data_out  output  BUS_SIZE  registered word of the last accepted channel.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  sink accepts data_out this cycle.
- grant  output  $clog2(CHANNELS)  registered index of the channel whose word is in data_out.

## Operation
- Output stage is one register: {out_valid, data_out, grant}.
- load = ~out_valid | out_ready. This means the register is empty or is drained this cycle.
- Requester selection, combinational:
  - ARB_MODE=0: lowest index i with in_valid[i].
  - ARB_MODE=1: first i with in_valid[i], searching from ptr upward and wrapping from CHANNELS-1 to 0.
- in_ready[sel] = load & |in_valid. All other bits are 0, and in_ready is all 0 when no channel is valid.
  - in_ready depends combinationally on in_valid and out_ready. There is no path from in_ready back to in_valid.
- Transfer on channel i: in_valid[i] & in_ready[i]. On the next edge:
  - data_out <= data_in[sel]
  - grant <= sel
  - out_valid <= 1
- Drain without a new load (out_valid & out_ready & no requester): out_valid <= 0. data_out and grant hold their values.
- Stall (out_valid & ~out_ready): data_out, grant and out_valid hold, and in_ready is all 0.
- Round-robin pointer ptr ($clog2(CHANNELS) bits):
  - On each input transfer, ptr <= (sel == CHANNELS-1) ? 0 : sel+1. This gives explicit wrap for non-power-of-2 CHANNELS.
  - Otherwise ptr holds. ptr is unused when ARB_MODE=0.
- Producers must hold in_valid and data stable until accepted. Data is sampled only on the transfer cycle.
- Reset values: out_valid=0, data_out=0, grant=0, ptr=0. in_ready is all 0 during reset regardless of inputs.
- Reset mid-operation: any word held in the register is discarded and no input transfer occurs in the reset cycle.

## Timing
- Latency: a word accepted at edge n appears on data_out with out_valid=1 after edge n (visible in cycle n+1).
- Back-to-back: with out_ready held high and requests pending, one transfer per cycle and no bubbles.
- Simultaneous drain and load in the same cycle are legal and required to be bubble-free.
- Fairness, ARB_MODE=1: a continuously requesting channel is granted within CHANNELS transfers.
- Fairness, ARB_MODE=0: no guarantee; starvation of higher indices is allowed.
- After reset deassertion, the first input transfer can occur in the first cycle with reset=0.

## Test plan
- Single channel, CHANNELS=4, BUS_SIZE=32, out_ready=1, in_valid=4'b0100, data_in[2]=32'hDEADBEEF. Required: in_ready=4'b0100 that cycle; next cycle data_out=32'hDEADBEEF, grant=2, out_valid=1.
- Round-robin rotation, ARB_MODE=1, in_valid=4'b1111 held, out_ready=1. Required: grant sequence 0,1,2,3,0,… with one transfer per cycle. Repeat with CHANNELS=3; required grant sequence 0,1,2,0,1 (wrap with no index 3).
- Fixed priority, ARB_MODE=0, in_valid=4'b1010 held. Required: every grant=1; channel 3 never gets in_ready.
- Backpressure: load word A from channel 0, then out_ready=0 for 5 cycles with in_valid=4'b0010. Required: data_out stays A, in_ready=0 for all 5 cycles. Then raise out_ready; required: the same cycle gives in_ready=4'b0010, and B appears the next cycle.
- Drain to empty: one word, out_ready=1, then in_valid=0. Required: out_valid falls after one cycle while data_out keeps its last value.
- Reset mid-stream: assert reset while out_valid=1 and ptr=2. Required: next cycle out_valid=0, data_out=0, grant=0, in_ready=0. The first post-reset round-robin grant with in_valid=4'b1111 is channel 0.
